// File: rtl/pipe_stall_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: stall codes are combinational from inputs and state,
// a redirect that collides with an outstanding fetch is held in DRAIN until if_ready.
module pipe_stall_ctrl #(
  parameter int PC_W  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic             if_ready,
  input  logic             me_mem_req,
  input  logic             me_mem_ready,
  input  logic             id_rs1_rena,
  input  logic [4:0]       id_rs1_raddr,
  input  logic             id_rs2_rena,
  input  logic [4:0]       id_rs2_raddr,
  input  logic             ex_mem_rena,
  input  logic [4:0]       ex_rd_waddr,
  input  logic             me_redirect,
  input  logic [PC_W-1:0]  me_target_pc,
  output logic [1:0]       pc_stall,
  output logic [1:0]       if_id_stall,
  output logic [1:0]       id_ex_stall,
  output logic [1:0]       ex_me_stall,
  output logic [1:0]       me_wb_stall,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] STALL_NEXT = 2'b00;
  localparam logic [1:0] STALL_KEEP = 2'b01;
  localparam logic [1:0] STALL_ZERO = 2'b10;

  typedef enum logic {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_wait;
  logic fetch_wait;
  logic load_use;

  assign mem_wait   = me_mem_req & ~me_mem_ready;
  assign fetch_wait = if_req & ~if_ready;
  assign load_use   = ex_mem_rena & (ex_rd_waddr != 5'd0) &
                      ((id_rs1_rena & (id_rs1_raddr == ex_rd_waddr)) |
                       (id_rs2_rena & (id_rs2_raddr == ex_rd_waddr)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pend_pc_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_pc_q   <= pend_pc_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      ST_RUN: begin
        // A memory instruction in ME never redirects, so mem_wait masks the redirect.
        if (!mem_wait && me_redirect && fetch_wait) begin
          state_d   = ST_DRAIN;
          pend_pc_d = me_target_pc;
        end
      end
      ST_DRAIN: begin
        if (if_ready) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    pc_stall       = STALL_NEXT;
    if_id_stall    = STALL_NEXT;
    id_ex_stall    = STALL_NEXT;
    ex_me_stall    = STALL_NEXT;
    me_wb_stall    = STALL_NEXT;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (rst) begin
      pc_stall    = STALL_ZERO;
      if_id_stall = STALL_ZERO;
      id_ex_stall = STALL_ZERO;
      ex_me_stall = STALL_ZERO;
      me_wb_stall = STALL_ZERO;
    end else if (state_q == ST_DRAIN) begin
      // Only bubbles sit behind ME here; the fetched word on if_ready is stale and dropped.
      if_id_stall = STALL_ZERO;
      id_ex_stall = STALL_ZERO;
      ex_me_stall = STALL_ZERO;
      if (if_ready) begin
        redirect_valid = 1'b1;
        redirect_pc    = pend_pc_q;
      end else begin
        pc_stall = STALL_KEEP;
      end
    end else if (mem_wait) begin
      pc_stall    = STALL_KEEP;
      if_id_stall = STALL_KEEP;
      id_ex_stall = STALL_KEEP;
      ex_me_stall = STALL_KEEP;
      me_wb_stall = STALL_ZERO;
    end else if (me_redirect) begin
      if_id_stall = STALL_ZERO;
      id_ex_stall = STALL_ZERO;
      ex_me_stall = STALL_ZERO;
      if (fetch_wait) begin
        pc_stall = STALL_KEEP;
      end else begin
        redirect_valid = 1'b1;
        redirect_pc    = me_target_pc;
      end
    end else if (load_use) begin
      pc_stall    = STALL_KEEP;
      if_id_stall = STALL_KEEP;
      id_ex_stall = STALL_ZERO;
    end else if (fetch_wait) begin
      pc_stall    = STALL_KEEP;
      if_id_stall = STALL_ZERO;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (pc_stall == STALL_KEEP && stall_cnt_q != {CNT_W{1'b1}})
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: expectations queued as stimulus is driven, checked at negedge.
module tb_pipe_stall_ctrl;

  localparam int PC_W  = 64;
  localparam int CNT_W = 4;
  localparam logic [1:0] N = 2'b00;
  localparam logic [1:0] K = 2'b01;
  localparam logic [1:0] Z = 2'b10;

  typedef struct packed {
    logic [9:0]      codes;
    logic            rv;
    logic [PC_W-1:0] rpc;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  typedef struct packed {
    logic            if_req;
    logic            if_ready;
    logic            mem_req;
    logic            mem_ready;
    logic            rs1_en;
    logic [4:0]      rs1;
    logic            rs2_en;
    logic [4:0]      rs2;
    logic            ld;
    logic [4:0]      rd;
    logic            redir;
    logic [PC_W-1:0] tgt;
  } in_t;

  logic             clk, rst;
  logic             if_req, if_ready, me_mem_req, me_mem_ready;
  logic             id_rs1_rena, id_rs2_rena, ex_mem_rena, me_redirect;
  logic [4:0]       id_rs1_raddr, id_rs2_raddr, ex_rd_waddr;
  logic [PC_W-1:0]  me_target_pc;
  logic [1:0]       pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] stall_cnt;

  int total = 0;
  int bad   = 0;
  exp_t sb[$];
  logic [CNT_W-1:0] exp_cnt = '0;

  pipe_stall_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_ready(if_ready),
    .me_mem_req(me_mem_req), .me_mem_ready(me_mem_ready),
    .id_rs1_rena(id_rs1_rena), .id_rs1_raddr(id_rs1_raddr),
    .id_rs2_rena(id_rs2_rena), .id_rs2_raddr(id_rs2_raddr),
    .ex_mem_rena(ex_mem_rena), .ex_rd_waddr(ex_rd_waddr),
    .me_redirect(me_redirect), .me_target_pc(me_target_pc),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_me_stall(ex_me_stall), .me_wb_stall(me_wb_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic apply(input in_t s);
    if_req       = s.if_req;
    if_ready     = s.if_ready;
    me_mem_req   = s.mem_req;
    me_mem_ready = s.mem_ready;
    id_rs1_rena  = s.rs1_en;
    id_rs1_raddr = s.rs1;
    id_rs2_rena  = s.rs2_en;
    id_rs2_raddr = s.rs2;
    ex_mem_rena  = s.ld;
    ex_rd_waddr  = s.rd;
    me_redirect  = s.redir;
    me_target_pc = s.tgt;
  endtask

  // Queue the expected outputs for this cycle; stall_cnt shows the KEEP cycles seen before it.
  task automatic push_exp(input logic [9:0] codes, input logic rv, input logic [PC_W-1:0] rpc);
    exp_t e;
    e.codes = codes;
    e.rv    = rv;
    e.rpc   = rpc;
    e.cnt   = exp_cnt;
    sb.push_back(e);
    if (codes[9:8] == K && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
  endtask

  function automatic exp_t observe();
    exp_t o;
    o.codes = {pc_stall, if_id_stall, id_ex_stall, ex_me_stall, me_wb_stall};
    o.rv    = redirect_valid;
    o.rpc   = redirect_pc;
    o.cnt   = stall_cnt;
    return o;
  endfunction

  task automatic test_reset();
    in_t s = '0;
    exp_t got, want;
    rst = 1'b1;
    s.redir = 1'b1; s.tgt = 64'h1234; s.mem_req = 1'b1; s.if_req = 1'b1;
    apply(s);
    exp_cnt = '0;
    push_exp({Z, Z, Z, Z, Z}, 1'b0, '0);
    @(negedge clk);
    got = observe(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL reset got=%h want=%h", got, want); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_idle();
    exp_t got, want;
    for (int c = 0; c < 10; c++) begin
      apply('0);
      push_exp({N, N, N, N, N}, 1'b0, '0);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL idle[%0d] got=%h want=%h", c, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_wait();
    in_t s = '0;
    exp_t got, want;
    for (int c = 0; c < 4; c++) begin
      s.mem_req = 1'b1;
      s.mem_ready = (c == 3);
      s.redir = (c == 1);
      s.tgt = 64'hdead_0000;
      apply(s);
      if (c < 3) push_exp({K, K, K, K, Z}, 1'b0, '0);
      else       push_exp({N, N, N, N, N}, 1'b0, '0);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL mem_wait[%0d] got=%h want=%h", c, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    in_t li[5];
    logic [9:0] lc[5];
    exp_t got, want;
    foreach (li[i]) li[i] = '0;
    li[0].ld = 1'b1; li[0].rd = 5'd5; li[0].rs2_en = 1'b1; li[0].rs2 = 5'd5;
    lc[0] = {K, K, Z, N, N};
    li[1].ld = 1'b1; li[1].rd = 5'd0; li[1].rs2_en = 1'b1; li[1].rs2 = 5'd0;
    lc[1] = {N, N, N, N, N};
    li[2].ld = 1'b1; li[2].rd = 5'd7; li[2].rs1_en = 1'b1; li[2].rs1 = 5'd7; li[2].if_req = 1'b1;
    lc[2] = {K, K, Z, N, N};
    li[3].ld = 1'b0; li[3].rd = 5'd7; li[3].rs1_en = 1'b1; li[3].rs1 = 5'd7;
    lc[3] = {N, N, N, N, N};
    li[4].ld = 1'b1; li[4].rd = 5'd9; li[4].rs1_en = 1'b0; li[4].rs1 = 5'd9; li[4].rs2_en = 1'b1; li[4].rs2 = 5'd8;
    lc[4] = {N, N, N, N, N};
    for (int c = 0; c < 5; c++) begin
      apply(li[c]);
      push_exp(lc[c], 1'b0, '0);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL load_use[%0d] got=%h want=%h", c, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fetch_wait();
    in_t s = '0;
    exp_t got, want;
    for (int c = 0; c < 3; c++) begin
      s.if_req = 1'b1;
      s.if_ready = (c == 2);
      apply(s);
      if (c < 2) push_exp({K, Z, N, N, N}, 1'b0, '0);
      else       push_exp({N, N, N, N, N}, 1'b0, '0);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL fetch_wait[%0d] got=%h want=%h", c, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_redirect_now();
    in_t s = '0;
    exp_t got, want;
    for (int c = 0; c < 2; c++) begin
      s = '0;
      s.if_req = 1'b1; s.if_ready = 1'b1;
      if (c == 0) begin
        s.redir = 1'b1; s.tgt = 64'h8000_0100;
        push_exp({N, Z, Z, Z, N}, 1'b1, 64'h8000_0100);
      end else begin
        push_exp({N, N, N, N, N}, 1'b0, '0);
      end
      apply(s);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL redirect_now[%0d] got=%h want=%h", c, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_drain();
    in_t s;
    exp_t got, want;
    for (int c = 0; c < 5; c++) begin
      s = '0;
      s.if_req = (c < 4);
      case (c)
        0: begin s.redir = 1'b1; s.tgt = 64'h8000_0200;
                 push_exp({K, Z, Z, Z, Z ^ Z}, 1'b0, '0); end
        1: begin s.redir = 1'b1; s.tgt = 64'h9999_0000; s.mem_req = 1'b1;
                 push_exp({K, Z, Z, Z, N}, 1'b0, '0); end
        2: begin s.ld = 1'b1; s.rd = 5'd3; s.rs1_en = 1'b1; s.rs1 = 5'd3;
                 push_exp({K, Z, Z, Z, N}, 1'b0, '0); end
        3: begin s.if_ready = 1'b1;
                 push_exp({N, Z, Z, Z, N}, 1'b1, 64'h8000_0200); end
        default: push_exp({N, N, N, N, N}, 1'b0, '0);
      endcase
      apply(s);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL drain[%0d] got=%h want=%h", c, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturate();
    in_t s = '0;
    exp_t got, want;
    s.if_req = 1'b1;
    for (int c = 0; c < 20; c++) begin
      apply(s);
      push_exp({K, Z, N, N, N}, 1'b0, '0);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL saturate[%0d] got=%h want=%h", c, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_drain();
    in_t s = '0;
    exp_t got, want;
    s.if_req = 1'b1; s.redir = 1'b1; s.tgt = 64'h8000_0300;
    apply(s);
    push_exp({K, Z, Z, Z, N}, 1'b0, '0);
    @(negedge clk);
    got = observe(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL rst_drain_enter got=%h want=%h", got, want); end
    @(posedge clk); #1;
    s.redir = 1'b0;
    apply(s);
    #2 rst = 1'b1;
    exp_cnt = '0;
    push_exp({Z, Z, Z, Z, Z}, 1'b0, '0);
    @(negedge clk);
    got = observe(); want = sb.pop_front(); total++;
    if (got !== want) begin bad++; $display("FAIL rst_drain_hold got=%h want=%h", got, want); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 2; c++) begin
      s = '0;
      s.if_req = 1'b1; s.if_ready = 1'b1;
      apply(s);
      push_exp({N, N, N, N, N}, 1'b0, '0);
      @(negedge clk);
      got = observe(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL rst_drain_after[%0d] got=%h want=%h", c, got, want); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    apply('0);
    rst = 1'b1;
    test_reset();
    test_idle();
    test_mem_wait();
    test_load_use();
    test_fetch_wait();
    test_redirect_now();
    test_drain();
    test_saturate();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
- Central stall/flush scheduler for the five-stage pipeline.
- Each cycle it computes the 2-bit stall code for the PC register and for the if_id, id_ex, ex_me and me_wb pipeline registers.
- Its inputs are the memory handshakes, load-use hazards and control-flow redirects resolved in ME.
- It holds a registered redirect when a redirect collides with an outstanding instruction fetch, and it keeps a stall-cycle performance counter.

Parameters:
- PC_W, 64, width of redirect target.
- CNT_W, 32, width of stall-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- if_req  in  1  fetch stage has an instruction request outstanding
- if_ready  in  1  instruction returned this cycle
- me_mem_req  in  1  ME instruction accesses data memory (rena|wena)
- me_mem_ready  in  1  data access completes this cycle
- id_rs1_rena  in  1  ID reads rs1
- id_rs1_raddr  in  5  ID rs1 index
- id_rs2_rena  in  1  ID reads rs2
- id_rs2_raddr  in  5  ID rs2 index
- ex_mem_rena  in  1  EX instruction is a load
- ex_rd_waddr  in  5  EX destination index
- me_redirect  in  1  taken branch or jump resolved in ME
- me_target_pc  in  PC_W  redirect target from ME
- pc_stall  out  2  stall code for the PC register
- if_id_stall  out  2  stall code for if_id
- id_ex_stall  out  2  stall code for id_ex
- ex_me_stall  out  2  stall code for ex_me
- me_wb_stall  out  2  stall code for me_wb
- redirect_valid  out  1  PC must load redirect_pc this cycle
- redirect_pc  out  PC_W  redirect target
- stall_cnt  out  CNT_W  count of cycles with pc_stall=KEEP

Behaviour:
- Stall codes are taken from defines.v: STALL_NEXT=2'b00 (load input), STALL_KEEP=2'b01 (hold), STALL_ZERO=2'b10 (insert bubble).
- Stall outputs are combinational from the inputs and the registered state. State is the FSM, the pending PC and the counter.
- Reset (asynchronous, any cycle, including mid-DRAIN):
  - state=RUN, pend_pc=0, stall_cnt=0.
  - While rst=1: all stall outputs=ZERO, redirect_valid=0, redirect_pc=0.
- FSM states:
  - RUN: normal operation.
  - DRAIN: a redirect is latched and waiting for the outstanding fetch to return.
- Derived signals:
  - mem_wait = me_mem_req & ~me_mem_ready.
  - fetch_wait = if_req & ~if_ready.
  - load_use = ex_mem_rena & (ex_rd_waddr!=0) & ((id_rs1_rena & id_rs1_raddr==ex_rd_waddr) | (id_rs2_rena & id_rs2_raddr==ex_rd_waddr)).
- RUN priority (first match wins):
  1. mem_wait:
     - pc, if_id, id_ex, ex_me = KEEP; me_wb = ZERO.
     - me_redirect is ignored; a memory instruction never redirects.
  2. me_redirect & ~fetch_wait:
     - redirect_valid=1, redirect_pc=me_target_pc, pc=NEXT.
     - if_id, id_ex, ex_me = ZERO; me_wb = NEXT.
  3. me_redirect & fetch_wait:
     - pend_pc<=me_target_pc; next state DRAIN.
     - pc=KEEP; if_id, id_ex, ex_me = ZERO; me_wb = NEXT; redirect_valid=0.
  4. load_use:
     - pc=KEEP, if_id=KEEP, id_ex=ZERO; ex_me, me_wb = NEXT.
     - This case also covers a simultaneous fetch_wait; if_id KEEP overrides a bubble.
  5. fetch_wait: pc=KEEP, if_id=ZERO; id_ex, ex_me, me_wb = NEXT.
  6. Otherwise: all NEXT.
- DRAIN:
  - pc=KEEP; if_id, id_ex, ex_me = ZERO; me_wb=NEXT; redirect_valid=0.
  - me_redirect, load_use and mem_wait are ignored, since the pipeline holds only bubbles.
  - On if_ready:
    - redirect_valid=1, redirect_pc=pend_pc, pc=NEXT.
    - if_id=ZERO, discarding the stale fetched instruction.
    - Next state RUN.
- redirect_pc=0 whenever redirect_valid=0.
- stall_cnt increments by 1 in every cycle with pc_stall==KEEP (rst=0). It saturates at all-ones and does not wrap.
- Latency:
  - Stall codes take effect at the next posedge of the consuming registers.
  - A redirect is applied the same cycle when no fetch is outstanding.
  - Otherwise it is applied in the if_ready cycle.

Test Plan:
- Idle, no hazards for 10 cycles -> all stall outputs 2'b00, redirect_valid=0, stall_cnt=0.
- me_mem_req=1, me_mem_ready=0 for 3 cycles, then ready -> 3 cycles with pc/if_id/id_ex/ex_me=01 and me_wb=10; stall_cnt=3; all 00 on the ready cycle.
- EX load with rd=5 and ID rs2 reads x5 -> one cycle pc=01, if_id=01, id_ex=10. The same setup with rd=0 -> all 00.
- me_redirect=1, target 0x8000_0100, if_req=1, if_ready=1 -> redirect_valid=1, redirect_pc=0x8000_0100, if_id/id_ex/ex_me=10; state stays RUN.
- me_redirect with target 0x8000_0200 while fetch is outstanding, then if_ready after 2 cycles -> DRAIN for 2 cycles with pc=01 and redirect_valid=0. On the if_ready cycle: redirect_valid=1, redirect_pc=0x8000_0200, if_id=10.
- Assert rst mid-DRAIN -> all stall outputs=10 immediately, stall_cnt=0; after release, state RUN with no redirect issued.
